// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling and framing-error detection.
// Define UART_RX_MAJORITY_EN to decide each bit by a 3-sample majority vote instead of a single sample.
module uart_rx #(
   parameter logic [15:0] CLK_DIV = 16'd217
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx,
   output logic       o_en,
   output logic [7:0] o_data,
   output logic       o_ferr
);

   localparam logic [15:0] HALF = CLK_DIV >> 1;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   state_t      state, state_n;
   logic        rx_m, rx_s;
   logic [15:0] ccnt, ccnt_n;
   logic [2:0]  bcnt, bcnt_n;
   logic [7:0]  shreg, shreg_n, data_n;
   logic        en_n, ferr_n;
   logic        bit_v;
   logic [16:0] ccnt_inc;
   logic        bit_end, half_end;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   // hist holds rx_s from the two preceding cycles
   logic [1:0] hist;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) hist <= 2'b11;
      else       hist <= {hist[0], rx_s};
   end
   assign bit_v = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
   assign bit_v = rx_s;
`endif

   // 17-bit compare so CLK_DIV=65535 cannot wrap
   assign ccnt_inc = {1'b0, ccnt} + 17'd1;
   assign bit_end  = !(ccnt_inc < {1'b0, CLK_DIV});
   assign half_end = !(ccnt_inc < {1'b0, HALF});

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= IDLE;
         ccnt   <= '0;
         bcnt   <= '0;
         shreg  <= '0;
         o_data <= '0;
         o_en   <= 1'b0;
         o_ferr <= 1'b0;
      end else begin
         state  <= state_n;
         ccnt   <= ccnt_n;
         bcnt   <= bcnt_n;
         shreg  <= shreg_n;
         o_data <= data_n;
         o_en   <= en_n;
         o_ferr <= ferr_n;
      end
   end

   always_comb begin
      state_n = state;
      ccnt_n  = ccnt;
      bcnt_n  = bcnt;
      shreg_n = shreg;
      data_n  = o_data;
      en_n    = 1'b0;
      ferr_n  = 1'b0;
      case (state)
         IDLE: begin
            ccnt_n = '0;
            bcnt_n = '0;
            if (!rx_s) state_n = START;
         end
         START: begin
            if (half_end) begin
               ccnt_n  = '0;
               state_n = bit_v ? IDLE : DATA;
            end else begin
               ccnt_n = ccnt_inc[15:0];
            end
         end
         DATA: begin
            if (bit_end) begin
               ccnt_n  = '0;
               shreg_n = {bit_v, shreg[7:1]};
               if (bcnt == 3'd7) begin
                  bcnt_n  = '0;
                  state_n = STOP;
               end else begin
                  bcnt_n = bcnt + 3'd1;
               end
            end else begin
               ccnt_n = ccnt_inc[15:0];
            end
         end
         STOP: begin
            // leave at mid stop bit so a following start edge is never missed
            if (bit_end) begin
               ccnt_n = '0;
               if (bit_v) begin
                  data_n  = shreg;
                  en_n    = 1'b1;
                  state_n = IDLE;
               end else begin
                  ferr_n  = 1'b1;
                  state_n = BRK;
               end
            end else begin
               ccnt_n = ccnt_inc[15:0];
            end
         end
         BRK: begin
            ccnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: vector table of frames plus hand sequences for glitch, break, reset and back-to-back.
module tb_uart_rx;

   localparam int CD   = 217;
   localparam int HALF = CD / 2;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rx = 1'b1;
   logic       o_en, o_ferr;
   logic [7:0] o_data;

   uart_rx #(.CLK_DIV(16'd217)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .rx    (rx),
      .o_en  (o_en),
      .o_data(o_data),
      .o_ferr(o_ferr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         errors = 0, checks = 0;
   int         en_cnt = 0, ferr_cnt = 0, both_cnt = 0, wide_cnt = 0;
   logic       prev_en = 1'b0;
   logic [7:0] rxq[$];
   int         en_cyc[$];

   always @(negedge clk) begin
      prev_en <= o_en;
      if (o_en) begin
         en_cnt <= en_cnt + 1;
         rxq.push_back(o_data);
         en_cyc.push_back(cyc);
         if (prev_en) wide_cnt <= wide_cnt + 1;
      end
      if (o_ferr) ferr_cnt <= ferr_cnt + 1;
      if (o_en && o_ferr) both_cnt <= both_cnt + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // One 10-bit frame at period p; spike inverts the mid-bit cycle of each data bit; cut>0 aborts early.
   task automatic send_frame(input logic [7:0] d, input int p, input logic stp,
                             input logic spike, input int cut);
      int   b;
      logic v;
      for (int c = 0; c < 10 * p; c++) begin
         if (cut > 0 && c >= cut) break;
         b = c / p;
         if (b == 0)      v = 1'b0;
         else if (b == 9) v = stp;
         else             v = d[b-1];
         if (spike && b >= 1 && b <= 8 && c == HALF + b * CD) v = ~v;
         rx = v;
         @(negedge clk);
      end
      rx = 1'b1;
   endtask

   typedef struct {
      logic [7:0] d;
      int         p;
      logic       spike;
      logic [7:0] exp;
   } vec_t;

   vec_t       vt[7];
   logic [7:0] lb[8];
   int         e0, f0, n0, t0, v;

   initial begin
      vt[0] = '{8'h55, 217, 1'b0, 8'h55};
      vt[1] = '{8'hA3, 217, 1'b0, 8'hA3};
      vt[2] = '{8'h0F, 210, 1'b0, 8'h0F};
      vt[3] = '{8'hF0, 210, 1'b0, 8'hF0};
      vt[4] = '{8'h0F, 224, 1'b0, 8'h0F};
      vt[5] = '{8'hF0, 224, 1'b0, 8'hF0};
`ifdef UART_RX_MAJORITY_EN
      vt[6] = '{8'h96, 217, 1'b1, 8'h96};
`else
      vt[6] = '{8'h96, 217, 1'b1, 8'h69};
`endif
      lb = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF, 8'h5A, 8'hC3};

      rx   = 1'b1;
      rstn = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_en", int'(o_en), 0);
      chk("rst_ferr", int'(o_ferr), 0);
      chk("rst_data", int'(o_data), 8'h00);
      rstn = 1'b1;
      idle(50);

      for (int i = 0; i < 7; i++) begin
         e0 = en_cnt;
         f0 = ferr_cnt;
         send_frame(vt[i].d, vt[i].p, 1'b1, vt[i].spike, 0);
         idle(vt[i].p);
         chk($sformatf("vec%0d_en", i), en_cnt - e0, 1);
         chk($sformatf("vec%0d_ferr", i), ferr_cnt - f0, 0);
         chk($sformatf("vec%0d_data", i), int'(o_data), int'(vt[i].exp));
      end

      // short low pulse on an idle line is rejected at the start-bit check
      e0 = en_cnt;
      f0 = ferr_cnt;
      rx = 1'b0;
      repeat (50) @(negedge clk);
      idle(400);
      chk("glitch_en", en_cnt - e0, 0);
      chk("glitch_ferr", ferr_cnt - f0, 0);
      send_frame(8'h3C, CD, 1'b1, 1'b0, 0);
      idle(CD);
      chk("post_glitch_en", en_cnt - e0, 1);
      chk("post_glitch_data", int'(o_data), 8'h3C);

      // bad stop bit followed by a long break
      e0 = en_cnt;
      f0 = ferr_cnt;
      send_frame(8'hA5, CD, 1'b0, 1'b0, 0);
      rx = 1'b0;
      repeat (3000) @(negedge clk);
      idle(2 * CD);
      chk("break_ferr", ferr_cnt - f0, 1);
      chk("break_en", en_cnt - e0, 0);
      chk("break_data_held", int'(o_data), 8'h3C);
      send_frame(8'h5A, CD, 1'b1, 1'b0, 0);
      idle(CD);
      chk("post_break_en", en_cnt - e0, 1);
      chk("post_break_data", int'(o_data), 8'h5A);

      // reset in the middle of data bit 4
      e0 = en_cnt;
      f0 = ferr_cnt;
      send_frame(8'hE7, CD, 1'b1, 1'b0, 5 * CD + 100);
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_en", int'(o_en), 0);
      chk("midrst_ferr", int'(o_ferr), 0);
      chk("midrst_data", int'(o_data), 8'h00);
      rstn = 1'b1;
      idle(2 * CD);
      chk("midrst_no_strobe", en_cnt - e0 + ferr_cnt - f0, 0);
      send_frame(8'h81, CD, 1'b1, 1'b0, 0);
      idle(CD);
      chk("post_rst_en", en_cnt - e0, 1);
      chk("post_rst_data", int'(o_data), 8'h81);

      // back-to-back frames with one stop bit, plus first-strobe latency
      e0 = en_cnt;
      n0 = rxq.size();
      t0 = cyc;
      for (int k = 0; k < 8; k++) send_frame(lb[k], CD, 1'b1, 1'b0, 0);
      idle(2 * CD);
      chk("b2b_count", en_cnt - e0, 8);
      for (int k = 0; k < 8; k++) begin
         v = (n0 + k < rxq.size()) ? int'(rxq[n0 + k]) : -1;
         chk($sformatf("b2b_data%0d", k), v, int'(lb[k]));
      end
      v = (n0 < en_cyc.size()) ? en_cyc[n0] - t0 : -1;
      chk_rng("latency", v, 2 + HALF + 9 * CD - 1, 2 + HALF + 9 * CD + 1);

      chk("en_ferr_overlap", both_cnt, 0);
      chk("en_pulse_width", wide_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
